// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the IO register bus arbiter and its benches.
package io_bus_pkg;

  localparam int IO_ADR_W = 14;
  localparam int IO_DAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_t;

  localparam logic [IO_ADR_W-1:0] SYS_LED_IO       = 14'h3F80;
  localparam logic [IO_ADR_W-1:0] SYS_UART_DATA_IO = 14'h3F81;
  localparam logic [IO_ADR_W-1:0] SYS_UART_STAT_IO = 14'h3F82;
  localparam logic [IO_ADR_W-1:0] SYS_TIMER_IO     = 14'h3F84;

endpackage

// File: rtl/io_bus_arbiter_rr_pick.sv
// Two-way chooser: round-robin against the last grant, or m1 wins ties when FIXED_PRI is set.
module io_rr_pick
  import io_bus_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic [1:0] i_req,
  input  grant_t     i_last_grant,
  output grant_t     o_grant
);

  // Winner of the current request pair; only meaningful when some request is high.
  always_comb begin
    o_grant = GNT_M0;
    case (i_req)
      2'b01:   o_grant = GNT_M0;
      2'b10:   o_grant = GNT_M1;
      2'b11: begin
        if (FIXED_PRI) begin
          o_grant = GNT_M1;
        end else begin
          o_grant = (i_last_grant == GNT_M0) ? GNT_M1 : GNT_M0;
        end
      end
      default: o_grant = GNT_M0;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Serialises CPU (m0) and debug/DMA (m1) accesses onto the shared 16-bit IO register bus.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter bit                  FIXED_PRI = 1'b0,
  parameter logic [IO_ADR_W-1:0] IDLE_ADR  = 14'h0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [IO_ADR_W-1:0] m0_adr,
  input  logic [IO_DAT_W-1:0] m0_wdata,
  output logic                m0_ack,
  output logic [IO_DAT_W-1:0] m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [IO_ADR_W-1:0] m1_adr,
  input  logic [IO_DAT_W-1:0] m1_wdata,
  output logic                m1_ack,
  output logic [IO_DAT_W-1:0] m1_rdata,
  output logic                dma_io_we,
  output logic [IO_ADR_W-1:0] dma_io_wadr,
  output logic [IO_DAT_W-1:0] dma_io_wdata,
  output logic [IO_ADR_W-1:0] dma_io_radr,
  input  logic [IO_DAT_W-1:0] dma_io_rdata
);

  arb_state_t          r_state, w_state_nxt;
  grant_t              r_owner, w_owner_nxt;
  grant_t              r_last_grant, w_last_grant_nxt;
  grant_t              w_pick;
  logic                r_io_we, w_io_we_nxt;
  logic [IO_ADR_W-1:0] r_io_wadr, w_io_wadr_nxt;
  logic [IO_ADR_W-1:0] r_io_radr, w_io_radr_nxt;
  logic [IO_DAT_W-1:0] r_io_wdata, w_io_wdata_nxt;
  logic                r_m0_ack, w_m0_ack_nxt;
  logic                r_m1_ack, w_m1_ack_nxt;
  logic [IO_DAT_W-1:0] r_m0_rdata, w_m0_rdata_nxt;
  logic [IO_DAT_W-1:0] r_m1_rdata, w_m1_rdata_nxt;
  logic                w_any_req;
  logic                w_sel_we;
  logic [IO_ADR_W-1:0] w_sel_adr;
  logic [IO_DAT_W-1:0] w_sel_wdata;

  io_rr_pick #(
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .i_req        ({m1_req, m0_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick)
  );

  assign w_any_req   = m0_req | m1_req;
  assign w_sel_we    = (w_pick == GNT_M1) ? m1_we    : m0_we;
  assign w_sel_adr   = (w_pick == GNT_M1) ? m1_adr   : m0_adr;
  assign w_sel_wdata = (w_pick == GNT_M1) ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    case (r_state)
      IDLE:    w_state_nxt = w_any_req ? ACCESS : IDLE;
      ACCESS:  w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered bus/master outputs; request fields are only looked at in IDLE.
  always_comb begin
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_io_we_nxt      = r_io_we;
    w_io_wadr_nxt    = r_io_wadr;
    w_io_radr_nxt    = r_io_radr;
    w_io_wdata_nxt   = r_io_wdata;
    w_m0_ack_nxt     = 1'b0;
    w_m1_ack_nxt     = 1'b0;
    w_m0_rdata_nxt   = r_m0_rdata;
    w_m1_rdata_nxt   = r_m1_rdata;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_owner_nxt    = w_pick;
          w_io_we_nxt    = w_sel_we;
          w_io_wdata_nxt = w_sel_wdata;
          w_io_wadr_nxt  = w_sel_we ? w_sel_adr : IDLE_ADR;
          w_io_radr_nxt  = w_sel_we ? IDLE_ADR  : w_sel_adr;
        end else begin
          w_io_we_nxt    = 1'b0;
        end
      end
      ACCESS: begin
        w_io_we_nxt   = 1'b0;
        w_io_wadr_nxt = IDLE_ADR;
        w_io_radr_nxt = IDLE_ADR;
        if (r_owner == GNT_M1) begin
          w_m1_ack_nxt = 1'b1;
          if (!r_io_we) begin
            w_m1_rdata_nxt = dma_io_rdata;
          end else begin
            w_m1_rdata_nxt = r_m1_rdata;
          end
        end else begin
          w_m0_ack_nxt = 1'b1;
          if (!r_io_we) begin
            w_m0_rdata_nxt = dma_io_rdata;
          end else begin
            w_m0_rdata_nxt = r_m0_rdata;
          end
        end
      end
      DONE: begin
        w_last_grant_nxt = r_owner;
      end
      default: begin
        w_io_we_nxt   = 1'b0;
        w_io_wadr_nxt = IDLE_ADR;
        w_io_radr_nxt = IDLE_ADR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= GNT_M0;
      r_last_grant <= GNT_M1;
      r_io_we      <= 1'b0;
      r_io_wadr    <= IDLE_ADR;
      r_io_radr    <= IDLE_ADR;
      r_io_wdata   <= 16'h0000;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= 16'h0000;
      r_m1_rdata   <= 16'h0000;
    end else begin
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_io_we      <= w_io_we_nxt;
      r_io_wadr    <= w_io_wadr_nxt;
      r_io_radr    <= w_io_radr_nxt;
      r_io_wdata   <= w_io_wdata_nxt;
      r_m0_ack     <= w_m0_ack_nxt;
      r_m1_ack     <= w_m1_ack_nxt;
      r_m0_rdata   <= w_m0_rdata_nxt;
      r_m1_rdata   <= w_m1_rdata_nxt;
    end
  end

  assign dma_io_we    = r_io_we;
  assign dma_io_wadr  = r_io_wadr;
  assign dma_io_radr  = r_io_radr;
  assign dma_io_wdata = r_io_wdata;
  assign m0_ack       = r_m0_ack;
  assign m1_ack       = r_m1_ack;
  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one set of master stimuli.
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [13:0] m0_adr, m1_adr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [15:0] periph_val;
  logic [2:0]  led;

  logic        rr_m0_ack, rr_m1_ack, rr_we;
  logic [15:0] rr_m0_rdata, rr_m1_rdata, rr_wdata, rr_rdata;
  logic [13:0] rr_wadr, rr_radr;
  logic        fp_m0_ack, fp_m1_ack, fp_we;
  logic [15:0] fp_m0_rdata, fp_m1_rdata, fp_wdata, fp_rdata;
  logic [13:0] fp_wadr, fp_radr;

  int n_checks = 0;
  int n_errors = 0;

  // Peripheral chain model: returns periph_val only while a read address is on the bus.
  assign rr_rdata = (rr_radr == 14'h0000) ? 16'h0000 : periph_val;
  assign fp_rdata = (fp_radr == 14'h0000) ? 16'h0000 : periph_val;

  always @(posedge clk) begin
    if (rr_we && rr_wadr == SYS_LED_IO) led <= rr_wdata[2:0];
  end

  io_bus_arbiter #(.FIXED_PRI(1'b0), .IDLE_ADR(14'h0000)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_ack(rr_m0_ack), .m0_rdata(rr_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_ack(rr_m1_ack), .m1_rdata(rr_m1_rdata),
    .dma_io_we(rr_we), .dma_io_wadr(rr_wadr), .dma_io_wdata(rr_wdata),
    .dma_io_radr(rr_radr), .dma_io_rdata(rr_rdata)
  );

  io_bus_arbiter #(.FIXED_PRI(1'b1), .IDLE_ADR(14'h0000)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
    .dma_io_we(fp_we), .dma_io_wadr(fp_wadr), .dma_io_wdata(fp_wdata),
    .dma_io_radr(fp_radr), .dma_io_rdata(fp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One uncontended access on the round-robin instance, checked cycle by cycle.
  task automatic single_access(input logic m, input logic we, input logic [13:0] adr,
                               input logic [15:0] wd, input logic [15:0] rd);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_adr = adr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_adr = adr; m0_wdata = wd;
    end
    periph_val = rd;
    check_val("idle_we", 32'(rr_we), 32'(1'b0));
    tick();
    check_val("acc_we", 32'(rr_we), 32'(we));
    check_val("acc_wadr", 32'(rr_wadr), 32'(we ? adr : 14'h0000));
    check_val("acc_radr", 32'(rr_radr), 32'(we ? 14'h0000 : adr));
    if (we) check_val("acc_wdata", 32'(rr_wdata), 32'(wd));
    check_val("acc_ack", 32'({rr_m1_ack, rr_m0_ack}), 32'(2'b00));
    tick();
    check_val("done_ack", 32'({rr_m1_ack, rr_m0_ack}), 32'(m ? 2'b10 : 2'b01));
    check_val("done_we", 32'(rr_we), 32'(1'b0));
    check_val("done_adr", 32'({rr_wadr, rr_radr}), 32'(28'h0));
    m0_req = 1'b0;
    m1_req = 1'b0;
    periph_val = 16'hFFFF;
    tick();
    check_val("post_ack", 32'({rr_m1_ack, rr_m0_ack}), 32'(2'b00));
  endtask

  logic [1:0]  exp_rr, exp_fp;
  logic [13:0] exp_adr;

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_adr = 14'h0000; m0_wdata = 16'h0000;
    m1_req = 1'b0; m1_we = 1'b0; m1_adr = 14'h0000; m1_wdata = 16'h0000;
    periph_val = 16'h0000;
    led = 3'b000;
    tick();
    check_val("rst_we", 32'(rr_we), 32'(1'b0));
    check_val("rst_adr", 32'({rr_wadr, rr_radr}), 32'(28'h0));
    check_val("rst_wdata", 32'(rr_wdata), 32'(16'h0000));
    check_val("rst_ack", 32'({rr_m1_ack, rr_m0_ack}), 32'(2'b00));
    check_val("rst_rdata", 32'({rr_m1_rdata, rr_m0_rdata}), 32'h0);
    tick();
    rst = 1'b0;

    single_access(1'b0, 1'b1, SYS_LED_IO, 16'h0005, 16'h0000);
    check_val("led", 32'(led), 32'(3'b101));

    single_access(1'b1, 1'b0, SYS_LED_IO, 16'h0000, 16'h0003);
    check_val("m1_rd", 32'(rr_m1_rdata), 32'(16'h0003));
    check_val("m0_rd_untouched", 32'(rr_m0_rdata), 32'(16'h0000));

    single_access(1'b0, 1'b0, 14'h0010, 16'h0000, 16'hBEEF);
    check_val("m0_rd", 32'(rr_m0_rdata), 32'(16'hBEEF));
    check_val("m1_rd_hold", 32'(rr_m1_rdata), 32'(16'h0003));

    single_access(1'b1, 1'b1, SYS_UART_DATA_IO, 16'h0041, 16'h7777);
    check_val("m1_rd_after_wr", 32'(rr_m1_rdata), 32'(16'h0003));
    check_val("m0_rd_after_wr", 32'(rr_m0_rdata), 32'(16'hBEEF));

    // Request fields altered mid-access must not reach the bus until the next grant.
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = SYS_LED_IO; m0_wdata = 16'h0006;
    tick();
    m0_adr = 14'h0010; m0_wdata = 16'h00AA;
    #2;
    check_val("chg_wadr", 32'(rr_wadr), 32'(SYS_LED_IO));
    check_val("chg_wdata", 32'(rr_wdata), 32'(16'h0006));
    tick();
    check_val("chg_ack", 32'(rr_m0_ack), 32'(1'b1));
    tick();
    check_val("chg_idle_we", 32'(rr_we), 32'(1'b0));
    tick();
    check_val("chg_new_wadr", 32'(rr_wadr), 32'(14'h0010));
    check_val("chg_new_wdata", 32'(rr_wdata), 32'(16'h00AA));
    tick();
    check_val("chg_new_ack", 32'(rr_m0_ack), 32'(1'b1));
    m0_req = 1'b0;
    tick();

    // Reset in the middle of an m0 write.
    m0_req = 1'b1; m0_we = 1'b1; m0_adr = SYS_LED_IO; m0_wdata = 16'h0002;
    tick();
    check_val("abort_acc_we", 32'(rr_we), 32'(1'b1));
    #2 rst = 1'b1;
    #1;
    check_val("abort_we", 32'(rr_we), 32'(1'b0));
    check_val("abort_adr", 32'({rr_wadr, rr_radr}), 32'(28'h0));
    tick();
    check_val("abort_no_ack", 32'({rr_m1_ack, rr_m0_ack}), 32'(2'b00));
    rst = 1'b0;
    tick();
    check_val("retry_we", 32'(rr_we), 32'(1'b1));
    check_val("retry_wadr", 32'(rr_wadr), 32'(SYS_LED_IO));
    tick();
    check_val("retry_ack", 32'(rr_m0_ack), 32'(1'b1));
    m0_req = 1'b0;
    tick();

    // Both masters held high from reset: round-robin alternates, fixed priority starves m0.
    apply_reset();
    m0_we = 1'b1; m0_adr = 14'h0010; m0_wdata = 16'h1111;
    m1_we = 1'b1; m1_adr = 14'h0020; m1_wdata = 16'h2222;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_rr = (c == 2 || c == 8) ? 2'b01 : ((c == 5 || c == 11) ? 2'b10 : 2'b00);
      exp_fp = (c % 3 == 2) ? 2'b10 : 2'b00;
      exp_adr = (c % 3 != 1) ? 14'h0000 : ((c == 1 || c == 7) ? 14'h0010 : 14'h0020);
      check_val($sformatf("rr_ack_c%0d", c), 32'({rr_m1_ack, rr_m0_ack}), 32'(exp_rr));
      check_val($sformatf("fp_ack_c%0d", c), 32'({fp_m1_ack, fp_m0_ack}), 32'(exp_fp));
      check_val($sformatf("rr_wadr_c%0d", c), 32'(rr_wadr), 32'(exp_adr));
    end
    m1_req = 1'b0;
    for (int c = 13; c <= 15; c++) begin
      tick();
      exp_rr = (c == 14) ? 2'b01 : 2'b00;
      check_val($sformatf("rr_solo_c%0d", c), 32'({rr_m1_ack, rr_m0_ack}), 32'(exp_rr));
      check_val($sformatf("fp_solo_c%0d", c), 32'({fp_m1_ack, fp_m0_ack}), 32'(exp_rr));
      if (c == 13) check_val("fp_solo_wadr", 32'(fp_wadr), 32'(14'h0010));
    end
    m0_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single 16-bit IO register bus (dma_io_*) between two masters: the CPU load/store path (m0) and the debug/DMA command path (m1).
- Serialises accesses through a small state machine.
- Drives registered bus outputs toward the IO peripheral chain (LED, UART, etc.).
- Captures the chained read data and returns it to the winning master with a one-cycle ack.

Parameters:
- FIXED_PRI, 0, 0 = round-robin between m0/m1; 1 = m1 always wins simultaneous requests
- IDLE_ADR, 14'h0000, value driven on dma_io_wadr/dma_io_radr when no access is in progress

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  CPU access request, held until m0_ack
- m0_we  in  1  CPU write (1) / read (0)
- m0_adr  in  14  CPU word address [15:2]
- m0_wdata  in  16  CPU write data
- m0_ack  out  1  one-cycle completion pulse to CPU
- m0_rdata  out  16  read data for CPU, valid with m0_ack, held until next m0 read completes
- m1_req, m1_we, m1_adr, m1_wdata, m1_ack, m1_rdata  same as m0_*, for the debug/DMA master
- dma_io_we  out  1  bus write strobe
- dma_io_wadr  out  14  bus write address
- dma_io_wdata  out  16  bus write data
- dma_io_radr  out  14  bus read address
- dma_io_rdata  in  16  combinational read data returned by the peripheral chain

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, dma_io_we=0, dma_io_wadr=dma_io_radr=IDLE_ADR, dma_io_wdata=0
  - m0_ack=m1_ack=0, m0_rdata=m1_rdata=0
  - last_grant=m1, so m0 wins the first contention
- States:
  - IDLE: no access. If any req is high, choose a winner and latch its we/adr/wdata into the bus output registers and owner register; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: the bus outputs are stable for exactly this one cycle.
    - Write: dma_io_we=1, dma_io_wadr=adr.
    - Read: dma_io_we=0, dma_io_radr=adr, dma_io_wadr=IDLE_ADR.
    - At the end of the cycle, a read samples dma_io_rdata into owner's rdata register.
    - Go to DONE.
  - DONE:
    - Bus returns to idle values (we=0, adr=IDLE_ADR).
    - owner_ack=1 for this cycle only; last_grant=owner.
    - Go to IDLE.
- Winner selection in IDLE:
  - Only one req: that master wins.
  - Both reqs, FIXED_PRI=0: the master that is not last_grant wins.
  - Both reqs, FIXED_PRI=1: m1 wins.
- Latency: req seen in IDLE at cycle N -> bus access at N+1 -> ack at N+2. Minimum 3 cycles per access; back-to-back accesses from one master take 3 cycles each.
- Master rule: req/we/adr/wdata are held stable until ack. The master drops or re-asserts req on the cycle after ack. The arbiter samples request fields only in IDLE; changes during ACCESS/DONE are ignored.
- A req deasserted before grant is simply not served. A req deasserted after grant still completes and acks.
- The loser's req stays pending and is granted in the next IDLE. Max wait for either master is one foreign access (3 cycles) under round-robin.
- m0_rdata/m1_rdata update only on their own completed reads. Writes do not alter rdata.
- dma_io_wdata holds its last value in IDLE/DONE; only dma_io_we qualifies it.
- Reset mid-access:
  - Access is aborted and no ack is issued.
  - The bus returns to idle values immediately (asynchronous).
  - A write aborted during ACCESS may or may not have been taken by the peripheral. Software must not rely on it.

Decomposition:
- Shared package io_bus_pkg:
  - state encoding IDLE=2'd0, ACCESS=2'd1, DONE=2'd2
  - IO_ADR_W=14, IO_DAT_W=16
  - SYS_LED_IO=14'h3F80 and the other IO register address constants used by benches
- One sub-module, io_rr_pick: a combinational 2-way round-robin/fixed-priority chooser (inputs req[1:0], last_grant, FIXED_PRI; output grant). Everything else is in the top.

Test Plan:
- Single CPU write: m0_req, we=1, adr=14'h3F80, wdata=16'h0005 -> dma_io_we=1 with wadr=3F80/wdata=0005 for exactly one cycle at N+1; m0_ack pulse at N+2; LED model reads 3'b101.
- Single debug read: m1 read adr=3F80 with peripheral returning 16'h0003 -> dma_io_radr=3F80 at N+1; m1_ack at N+2; m1_rdata=0003 and held; m0_rdata stays 0.
- Simultaneous requests after reset, FIXED_PRI=0, both held -> order m0, m1, m0, m1; acks at cycles 2, 5, 8, 11 relative to first req.
- Same scenario with FIXED_PRI=1 -> m1 served every time both are pending; m0 served only when m1_req is low.
- Reset asserted during ACCESS of an m0 write -> dma_io_we=0 and addresses=IDLE_ADR in the same cycle; no m0_ack. After reset release with m0_req still high, the access restarts and acks 2 cycles later.
- Request fields changed during ACCESS (adr 3F80 -> 0010) -> bus keeps 3F80; ack returns; next access uses the new values.
